// File: rtl/sand_level_ctrl.sv
// sand_level_ctrl: timer-driven hourglass sand-level thresholds.
// Ports: clk, BTN_S (sync reset), start/pause/frame_start pulses;
// upper_row/lower_row row thresholds, running, done status.
// Optional SAND_FRAME_SYNC_EN: commit steps only on frame_start.
module sand_level_ctrl #(
  parameter int unsigned TICKS_PER_STEP = 25000000,
  parameter int unsigned UP_ORI         = 140,
  parameter int unsigned LOW_ORI        = 340,
  parameter int unsigned RADIUS         = 100
) (
  input  logic        clk,
  input  logic        BTN_S,
  input  logic        start,
  input  logic        pause,
  input  logic        frame_start,
  output logic [10:0] upper_row,
  output logic [10:0] lower_row,
  output logic        running,
  output logic        done
);

  localparam logic [10:0] U_FULL  = 11'(UP_ORI - RADIUS);
  localparam logic [10:0] U_EMPTY = 11'(UP_ORI + RADIUS + 1);
  localparam logic [10:0] L_EMPTY = 11'(LOW_ORI + RADIUS + 1);
  localparam logic [10:0] L_FULL  = 11'(LOW_ORI - RADIUS);
  localparam logic [10:0] U_LAST  = U_EMPTY - 11'd1;

  localparam int CW = $clog2(TICKS_PER_STEP);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICKS_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          expire;
  logic          commit;
  logic          last;

  assign expire = (state == RUN) && (cnt == CNT_MAX);
  assign last   = commit && (upper_row == U_LAST);

`ifdef SAND_FRAME_SYNC_EN
  logic pending;

  // An expiry on the frame_start cycle commits directly.
  assign commit = frame_start && (pending || expire) &&
                  ((state == RUN) || (state == PAUSE));
`else
  logic unused_frame_start;

  assign unused_frame_start = frame_start;
  assign commit = expire;
`endif

  always_ff @(posedge clk) begin
    if (BTN_S) begin
      state     <= IDLE;
      cnt       <= '0;
      upper_row <= U_FULL;
      lower_row <= L_EMPTY;
      running   <= 1'b0;
      done      <= 1'b0;
`ifdef SAND_FRAME_SYNC_EN
      pending   <= 1'b0;
`endif
    end else if (start) begin
      state     <= RUN;
      cnt       <= '0;
      upper_row <= U_FULL;
      lower_row <= L_EMPTY;
      running   <= 1'b1;
      done      <= 1'b0;
`ifdef SAND_FRAME_SYNC_EN
      pending   <= 1'b0;
`endif
    end else begin
      if (state == RUN)
        cnt <= expire ? '0 : cnt + 1'b1;
`ifdef SAND_FRAME_SYNC_EN
      // A second expiry while pending is dropped, not queued.
      if (commit)
        pending <= 1'b0;
      else if (expire)
        pending <= 1'b1;
`endif
      if (commit && (upper_row != U_EMPTY)) begin
        upper_row <= upper_row + 11'd1;
        lower_row <= lower_row - 11'd1;
      end
      if (last) begin
        state   <= DONE;
        running <= 1'b0;
        done    <= 1'b1;
      end else if (pause && (state == RUN)) begin
        state   <= PAUSE;
        running <= 1'b0;
      end else if (pause && (state == PAUSE)) begin
        state   <= RUN;
        running <= 1'b1;
      end
    end
  end

  // L_FULL is implied by U_EMPTY; kept for readability of the reload set.
  logic unused_lfull;
  assign unused_lfull = ^L_FULL;

endmodule

// File: tb/tb_sand_level_ctrl.sv
// tb_sand_level_ctrl: directed self-checking bench for sand_level_ctrl.
// Covers frame-synced and free-running builds via SAND_FRAME_SYNC_EN.
module tb_sand_level_ctrl;

  logic        clk = 1'b0;
  logic        BTN_S = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] upper_row;
  logic [10:0] lower_row;
  logic        running;
  logic        done;

  int checks = 0;
  int failures = 0;

  sand_level_ctrl #(
    .TICKS_PER_STEP(4),
    .UP_ORI(10),
    .LOW_ORI(30),
    .RADIUS(3)
  ) dut (
    .clk(clk),
    .BTN_S(BTN_S),
    .start(start),
    .pause(pause),
    .frame_start(frame_start),
    .upper_row(upper_row),
    .lower_row(lower_row),
    .running(running),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [10:0] obs,
                     input logic [10:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [10:0] u,
                         input logic [10:0] l, input logic r,
                         input logic d);
    chk({tag, ".upper"}, upper_row, u);
    chk({tag, ".lower"}, lower_row, l);
    chk({tag, ".running"}, {10'd0, running}, {10'd0, r});
    chk({tag, ".done"}, {10'd0, done}, {10'd0, d});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each pulse task drives for one edge and returns at the next negedge.
  task automatic p_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic p_pause();
    pause = 1'b1; tick(1); pause = 1'b0;
  endtask

  task automatic p_frame();
    frame_start = 1'b1; tick(1); frame_start = 1'b0;
  endtask

  initial begin
    tick(2);
    chk_all("reset", 11'd7, 11'd34, 1'b0, 1'b0);
    BTN_S = 1'b0;
    tick(1);

`ifdef SAND_FRAME_SYNC_EN
    // Full run: frames at edges 6,12,..,42 after start.
    p_start();
    chk_all("start", 11'd7, 11'd34, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      tick(5);
      p_frame();
      chk($sformatf("run.upper%0d", k), upper_row, 11'(7 + k));
      chk($sformatf("run.lower%0d", k), lower_row, 11'(34 - k));
    end
    chk_all("run_done", 11'd14, 11'd27, 1'b0, 1'b1);
    tick(3); p_frame();
    tick(3); p_frame();
    chk_all("after_done", 11'd14, 11'd27, 1'b0, 1'b1);

    // Frame sync: no frame for 20 cycles, then one step only.
    p_start();
    tick(20);
    chk_all("nosync", 11'd7, 11'd34, 1'b1, 1'b0);
    p_frame();
    chk_all("sync1", 11'd8, 11'd33, 1'b1, 1'b0);
    p_frame();
    chk_all("sync2", 11'd8, 11'd33, 1'b1, 1'b0);

    // Pause at edge 2 (count held at 2), frames leave rows alone.
    p_start();
    tick(1);
    p_pause();
    chk_all("paused", 11'd7, 11'd34, 1'b0, 1'b0);
    tick(2); p_frame();
    tick(1); p_frame();
    tick(1); p_frame();
    chk_all("pause_frames", 11'd7, 11'd34, 1'b0, 1'b0);
    // Resume at edge 10; expiry lands on edge 12.
    p_pause();
    chk_all("resume", 11'd7, 11'd34, 1'b1, 1'b0);
    p_frame();
    chk("resume.e11", upper_row, 11'd7);
    p_frame();
    chk("resume.e12", upper_row, 11'd8);
    chk("resume.e12l", lower_row, 11'd33);

    // Restart clears a pending step set at edge 4.
    p_start();
    tick(4);
    p_start();
    chk_all("restart", 11'd7, 11'd34, 1'b1, 1'b0);
    p_frame();
    chk("restart.nopend", upper_row, 11'd7);

    // Start and pause together: start wins.
    start = 1'b1; pause = 1'b1;
    tick(1);
    start = 1'b0; pause = 1'b0;
    chk_all("start_pause", 11'd7, 11'd34, 1'b1, 1'b0);
    tick(3);
    p_frame();
    chk("start_pause.step", upper_row, 11'd8);

    // Reset mid-run.
    BTN_S = 1'b1; tick(1); BTN_S = 1'b0;
    chk_all("midreset", 11'd7, 11'd34, 1'b0, 1'b0);
    tick(4); p_frame();
    chk("idle_frame", upper_row, 11'd7);
`else
    // Free-running: step on edges 4,8,..,28 after start.
    p_start();
    chk_all("start", 11'd7, 11'd34, 1'b1, 1'b0);
    tick(3);
    chk("e3.upper", upper_row, 11'd7);
    tick(1);
    chk_all("e4", 11'd8, 11'd33, 1'b1, 1'b0);
    tick(4);
    chk_all("e8", 11'd9, 11'd32, 1'b1, 1'b0);
    tick(19);
    chk_all("e27", 11'd13, 11'd28, 1'b1, 1'b0);
    tick(1);
    chk_all("e28_done", 11'd14, 11'd27, 1'b0, 1'b1);
    tick(8);
    chk_all("after_done", 11'd14, 11'd27, 1'b0, 1'b1);

    // frame_start must have no effect.
    p_start();
    tick(1); p_frame(); p_frame();
    chk("fs_ignored", upper_row, 11'd7);

    // Pause at edge 2 holds count 2; resume at P, step at P+2.
    p_start();
    tick(1);
    p_pause();
    chk_all("paused", 11'd7, 11'd34, 1'b0, 1'b0);
    tick(10);
    chk_all("pause_hold", 11'd7, 11'd34, 1'b0, 1'b0);
    p_pause();
    chk_all("resume", 11'd7, 11'd34, 1'b1, 1'b0);
    tick(1);
    chk("resume.p1", upper_row, 11'd7);
    tick(1);
    chk("resume.p2", upper_row, 11'd8);
    chk("resume.p2l", lower_row, 11'd33);

    // Restart reloads rows.
    tick(4);
    chk("pre_restart", upper_row, 11'd9);
    p_start();
    chk_all("restart", 11'd7, 11'd34, 1'b1, 1'b0);

    // Start and pause together: start wins, count restarts.
    tick(2);
    start = 1'b1; pause = 1'b1;
    tick(1);
    start = 1'b0; pause = 1'b0;
    chk_all("start_pause", 11'd7, 11'd34, 1'b1, 1'b0);
    tick(3);
    chk("sp.e3", upper_row, 11'd7);
    tick(1);
    chk("sp.e4", upper_row, 11'd8);

    // Reset mid-run.
    BTN_S = 1'b1; tick(1); BTN_S = 1'b0;
    chk_all("midreset", 11'd7, 11'd34, 1'b0, 1'b0);
    tick(8);
    chk("idle_hold", upper_row, 11'd7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
